// File: rtl/sram_arbiter.sv
// sram_arbiter: sequences every access to the shared 16-bit asynchronous SRAM
// and arbitrates among the loader (before init) and the PPU/CPU (after init).
// Each access runs IDLE -> SETUP -> STROBE (ACCESS_CYCLES) -> HOLD, so address,
// data and lanes settle one cycle before a strobe falls and stay one cycle
// after it rises. All outputs come straight from registers.
module sram_arbiter #(
  parameter int unsigned ACCESS_CYCLES = 2  // strobe width in cycles, 1..15
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_init_done,
  input  logic        i_ld_req,
  input  logic        i_ld_we,
  input  logic [20:0] i_ld_addr,
  input  logic [7:0]  i_ld_wdata,
  output logic        o_ld_ack,
  output logic [7:0]  o_ld_rdata,
  input  logic        i_ppu_req,
  input  logic [20:0] i_ppu_addr,
  output logic        o_ppu_ack,
  output logic [7:0]  o_ppu_rdata,
  input  logic        i_cpu_req,
  input  logic        i_cpu_we,
  input  logic [20:0] i_cpu_addr,
  input  logic [7:0]  i_cpu_wdata,
  output logic        o_cpu_ack,
  output logic [7:0]  o_cpu_rdata,
  output logic [19:0] o_sram_addr,
  output logic [15:0] o_sram_wdata,
  input  logic [15:0] i_sram_rdata,
  output logic        o_sram_oe_n,
  output logic        o_sram_we_n,
  output logic        o_sram_ub_n,
  output logic        o_sram_lb_n
);

  typedef enum logic [1:0] {ST_IDLE, ST_SETUP, ST_STROBE, ST_HOLD} state_t;
  typedef enum logic [1:0] {PORT_NONE, PORT_LD, PORT_PPU, PORT_CPU} port_t;

  localparam logic [3:0] LAST_CNT = 4'(ACCESS_CYCLES - 1);

  state_t      r_state, w_state;
  port_t       r_port, w_port;
  logic        r_we, w_we;
  logic        r_hi, w_hi;          // byte lane of the access: 1 = upper
  logic [3:0]  r_cnt, w_cnt;
  logic        r_last_ppu, w_last_ppu;
  logic [19:0] r_sram_addr, w_sram_addr;
  logic [15:0] r_sram_wdata, w_sram_wdata;
  logic        r_oe_n, w_oe_n, r_we_n, w_we_n, r_ub_n, w_ub_n, r_lb_n, w_lb_n;
  logic        r_ld_ack, w_ld_ack, r_ppu_ack, w_ppu_ack, r_cpu_ack, w_cpu_ack;
  logic [7:0]  r_ld_rdata, w_ld_rdata, r_ppu_rdata, w_ppu_rdata;
  logic [7:0]  r_cpu_rdata, w_cpu_rdata;
  logic [7:0]  w_rd_byte;
  logic        w_grant_ld, w_grant_ppu, w_grant_cpu;

  // Arbitration: init_done splits loader from PPU/CPU; PPU wins unless it had the last grant.
  always_comb begin
    w_grant_ld  = 1'b0;
    w_grant_ppu = 1'b0;
    w_grant_cpu = 1'b0;
    if (!i_init_done) begin
      w_grant_ld = i_ld_req;
    end else if (i_ppu_req && !(r_last_ppu && i_cpu_req)) begin
      w_grant_ppu = 1'b1;
    end else begin
      w_grant_cpu = i_cpu_req;
    end
  end

  assign w_rd_byte = r_hi ? i_sram_rdata[15:8] : i_sram_rdata[7:0];

  // Next-state and next-output logic for the access sequencer.
  always_comb begin
    w_state      = r_state;
    w_port       = r_port;
    w_we         = r_we;
    w_hi         = r_hi;
    w_cnt        = r_cnt;
    w_last_ppu   = r_last_ppu;
    w_sram_addr  = r_sram_addr;
    w_sram_wdata = r_sram_wdata;
    w_oe_n       = 1'b1;
    w_we_n       = 1'b1;
    w_ub_n       = r_ub_n;
    w_lb_n       = r_lb_n;
    w_ld_ack     = 1'b0;
    w_ppu_ack    = 1'b0;
    w_cpu_ack    = 1'b0;
    w_ld_rdata   = r_ld_rdata;
    w_ppu_rdata  = r_ppu_rdata;
    w_cpu_rdata  = r_cpu_rdata;
    case (r_state)
      ST_IDLE: begin
        w_ub_n = 1'b1;
        w_lb_n = 1'b1;
        if (w_grant_ld) begin
          w_state      = ST_SETUP;
          w_port       = PORT_LD;
          w_we         = i_ld_we;
          w_hi         = i_ld_addr[0];
          w_sram_addr  = i_ld_addr[20:1];
          w_sram_wdata = {i_ld_wdata, i_ld_wdata};
          w_ub_n       = ~i_ld_addr[0];
          w_lb_n       = i_ld_addr[0];
        end else if (w_grant_ppu) begin
          w_state      = ST_SETUP;
          w_port       = PORT_PPU;
          w_we         = 1'b0;            // PPU port is read-only
          w_hi         = i_ppu_addr[0];
          w_sram_addr  = i_ppu_addr[20:1];
          w_ub_n       = ~i_ppu_addr[0];
          w_lb_n       = i_ppu_addr[0];
          w_last_ppu   = 1'b1;
        end else if (w_grant_cpu) begin
          w_state      = ST_SETUP;
          w_port       = PORT_CPU;
          w_we         = i_cpu_we;
          w_hi         = i_cpu_addr[0];
          w_sram_addr  = i_cpu_addr[20:1];
          w_sram_wdata = {i_cpu_wdata, i_cpu_wdata};
          w_ub_n       = ~i_cpu_addr[0];
          w_lb_n       = i_cpu_addr[0];
          w_last_ppu   = 1'b0;
        end else begin
          w_state = ST_IDLE;
        end
      end
      ST_SETUP: begin
        w_state = ST_STROBE;
        w_cnt   = 4'd0;
        w_oe_n  = r_we;
        w_we_n  = ~r_we;
      end
      ST_STROBE: begin
        if (r_cnt == LAST_CNT) begin
          w_state = ST_HOLD;
          case (r_port)
            PORT_LD: begin
              w_ld_ack = 1'b1;
              if (!r_we) begin
                w_ld_rdata = w_rd_byte;
              end else begin
                w_ld_rdata = r_ld_rdata;
              end
            end
            PORT_PPU: begin
              w_ppu_ack   = 1'b1;
              w_ppu_rdata = w_rd_byte;
            end
            PORT_CPU: begin
              w_cpu_ack = 1'b1;
              if (!r_we) begin
                w_cpu_rdata = w_rd_byte;
              end else begin
                w_cpu_rdata = r_cpu_rdata;
              end
            end
            default: begin
              w_state = ST_HOLD;
            end
          endcase
        end else begin
          w_cnt  = r_cnt + 4'd1;
          w_oe_n = r_oe_n;
          w_we_n = r_we_n;
        end
      end
      ST_HOLD: begin
        w_state = ST_IDLE;
        w_port  = PORT_NONE;
        w_ub_n  = 1'b1;
        w_lb_n  = 1'b1;
      end
      default: begin
        w_state = ST_IDLE;
        w_ub_n  = 1'b1;
        w_lb_n  = 1'b1;
      end
    endcase
  end

  // State and output registers; a reset abandons any in-flight access without an ack.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state      <= ST_IDLE;
      r_port       <= PORT_NONE;
      r_we         <= 1'b0;
      r_hi         <= 1'b0;
      r_cnt        <= 4'd0;
      r_last_ppu   <= 1'b0;
      r_sram_addr  <= 20'd0;
      r_sram_wdata <= 16'd0;
      r_oe_n       <= 1'b1;
      r_we_n       <= 1'b1;
      r_ub_n       <= 1'b1;
      r_lb_n       <= 1'b1;
      r_ld_ack     <= 1'b0;
      r_ppu_ack    <= 1'b0;
      r_cpu_ack    <= 1'b0;
      r_ld_rdata   <= 8'd0;
      r_ppu_rdata  <= 8'd0;
      r_cpu_rdata  <= 8'd0;
    end else begin
      r_state      <= w_state;
      r_port       <= w_port;
      r_we         <= w_we;
      r_hi         <= w_hi;
      r_cnt        <= w_cnt;
      r_last_ppu   <= w_last_ppu;
      r_sram_addr  <= w_sram_addr;
      r_sram_wdata <= w_sram_wdata;
      r_oe_n       <= w_oe_n;
      r_we_n       <= w_we_n;
      r_ub_n       <= w_ub_n;
      r_lb_n       <= w_lb_n;
      r_ld_ack     <= w_ld_ack;
      r_ppu_ack    <= w_ppu_ack;
      r_cpu_ack    <= w_cpu_ack;
      r_ld_rdata   <= w_ld_rdata;
      r_ppu_rdata  <= w_ppu_rdata;
      r_cpu_rdata  <= w_cpu_rdata;
    end
  end

  assign o_ld_ack     = r_ld_ack;
  assign o_ld_rdata   = r_ld_rdata;
  assign o_ppu_ack    = r_ppu_ack;
  assign o_ppu_rdata  = r_ppu_rdata;
  assign o_cpu_ack    = r_cpu_ack;
  assign o_cpu_rdata  = r_cpu_rdata;
  assign o_sram_addr  = r_sram_addr;
  assign o_sram_wdata = r_sram_wdata;
  assign o_sram_oe_n  = r_oe_n;
  assign o_sram_we_n  = r_we_n;
  assign o_sram_ub_n  = r_ub_n;
  assign o_sram_lb_n  = r_lb_n;

endmodule

// File: doc/sram_arbiter.md
# sram_arbiter

Sequences every access to the shared 16-bit asynchronous SRAM that holds CHR/PRG data and arbitrates among three byte-wide requesters. The requesters are the flash-to-SRAM loader during initialization, and the PPU pattern fetch and CPU bus after initialization. The block sits between those requesters and the SRAM pins in the device manager and runs entirely in the PPU clock domain. It owns the SRAM strobes (oe/we/ub/lb) and guarantees setup/hold around every write pulse.

## Interface
- ACCESS_CYCLES, 2, number of cycles the oe_n/we_n strobe is held low per access; legal range 1..15.
- Reset is synchronous and active-high; the block has one clock.
- i_clk  in  1  PPU clock; all logic on rising edge
- i_rst  in  1  synchronous active-high reset
- i_init_done  in  1  0: only loader port is served; 1: only PPU/CPU ports are served
- i_ld_req / i_ld_we  in  1 / 1  loader request, write enable
- i_ld_addr  in  21  loader byte address
- i_ld_wdata  in  8  loader write byte
- o_ld_ack  out  1  one-cycle completion pulse
- o_ld_rdata  out  8  loader read byte
- i_ppu_req  in  1  PPU read request (read-only port)
- i_ppu_addr  in  21  PPU byte address
- o_ppu_ack  out  1  completion pulse
- o_ppu_rdata  out  8  PPU read byte
- i_cpu_req / i_cpu_we  in  1 / 1  CPU request, write enable
- i_cpu_addr  in  21  CPU byte address
- i_cpu_wdata  in  8  CPU write byte
- o_cpu_ack  out  1  completion pulse
- o_cpu_rdata  out  8  CPU read byte
- o_sram_addr  out  20  word address = byte_addr[20:1]
- o_sram_wdata  out  16  {wdata, wdata}
- i_sram_rdata  in  16  SRAM read data
- o_sram_oe_n / o_sram_we_n / o_sram_ub_n / o_sram_lb_n  out  1 each  active-low strobes

## Operation
- Handshake: the requester raises req with addr/we/wdata stable and holds them until ack. ack is high for exactly one cycle. rdata is valid in the ack cycle and is held until the next ack on the same port. req may stay high after ack to request again; that is a new access.
- Byte lane: addr[0]=1 selects the upper lane (ub_n=0, lb_n=1); addr[0]=0 selects the lower lane (lb_n=0, ub_n=1). Read data is i_sram_rdata[15:8] or [7:0] by addr[0].
- FSM states:
  - IDLE: all strobes high. Arbitrate; on a grant, latch address, we, wdata and the granted port, then go to SETUP.
  - SETUP: drive address, data and lane strobes for 1 cycle with oe_n=we_n=1, then go to STROBE.
  - STROBE: hold oe_n=0 (read) or we_n=0 (write) for ACCESS_CYCLES cycles, counted by a 4-bit counter. Read data is captured into the port's rdata register at the edge ending the last STROBE cycle. Then go to HOLD.
  - HOLD: oe_n=we_n=1, with address, data and lanes still driven. Assert the granted port's ack. Then go to IDLE.
- Arbitration, evaluated only in IDLE:
  - i_init_done=0: grant the loader if i_ld_req; PPU and CPU requests are never granted.
  - i_init_done=1: the loader is never granted. PPU has priority over CPU, except that if the last grant was PPU and i_cpu_req=1, the CPU is granted. When both ports request continuously, grants strictly alternate.
- A change of i_init_done during an access does not affect it; the in-flight access completes and acks.
- The PPU port ignores write semantics; it always reads.

## Timing
- Reset values: o_sram_oe_n=o_sram_we_n=o_sram_ub_n=o_sram_lb_n=1; o_sram_addr=0, o_sram_wdata=0; all acks 0; all rdata 0; FSM in IDLE; last-grant = CPU (so PPU wins the first contention).
- If req is sampled high in IDLE at edge k: SETUP occupies cycle k+1, STROBE occupies cycles k+2..k+1+N, and ack is high in cycle k+2+N (N=ACCESS_CYCLES).
- Back-to-back service has one mandatory IDLE cycle, so the access period is N+3 cycles (5 at default).
- Worst-case PPU latency from req to ack under CPU contention is 2N+5 cycles.
- Reset mid-access: at the reset edge, strobes go high, the FSM returns to IDLE, and no ack is issued. The requester must re-issue.
- Write safety: we_n never falls in the same cycle that address/lanes change, and address/data stay stable for one cycle after we_n rises.

## Test plan
- Reset: hold i_rst 3 cycles with random inputs -> all outputs match reset values; no ack for 10 cycles after release with no req.
- Loader write (i_init_done=0, N=2): addr 0x00005, data 0xA5 -> o_sram_addr=0x00002, wdata=0xA5A5, ub_n=0, lb_n=1, we_n low exactly 2 cycles, o_ld_ack 4 cycles after the sampled req. A simultaneous i_ppu_req is not acked.
- PPU reads (i_init_done=1), SRAM model returns 0x1234 -> addr 0x00010 gives o_ppu_rdata=0x34; addr 0x00011 gives 0x12; oe_n low 2 cycles each.
- Contention: PPU and CPU req held high for 6 grants -> ack order PPU, CPU, PPU, CPU, PPU, CPU, with acks 5 cycles apart.
- Reset asserted during the second STROBE cycle of a CPU write -> we_n=1 the next cycle, o_cpu_ack never pulses, FSM back in IDLE.
- i_init_done=1 with i_ld_req=1 and a CPU read of addr 0x1FFFFF -> o_ld_ack stays 0; CPU read completes with o_sram_addr=0xFFFFF and ub_n=0.
